// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_resp slice: FSM states, MMIO address, parameter defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned DEPTH_DEF       = 1024;
    localparam int unsigned WAIT_CYCLES_DEF = 2;

    // Byte accesses to this address hit the LED register instead of RAM.
    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FF00;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Byte-addressed RAM: synchronous byte write, asynchronous big-endian 4-byte word read.
// Latency: write commits at the clock edge, read is combinational.
// Backpressure: none; always accepts a write.
// Ports: clk, we_i/waddr_i/wdata_i (byte write), raddr_i (word index), rdata_o (word).
module mem_byte_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-3:0] raddr_i,
    output logic [31:0]   rdata_o
);

    // No reset: contents survive rst.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Lowest address lands in the most significant byte.
    assign rdata_o = {mem[{raddr_i, 2'd0}], mem[{raddr_i, 2'd1}],
                      mem[{raddr_i, 2'd2}], mem[{raddr_i, 2'd3}]};

endmodule

// File: rtl/mem_resp.sv
// Multi-cycle memory responder: word/byte reads, byte writes, LED MMIO register, error reporting.
// Latency: ready_o pulses WAIT_CYCLES+1 cycles after the accepting IDLE cycle.
// Backpressure: requests are only sampled in IDLE; inputs are ignored while busy.
// Ports: clk, rst (sync, active-high); memread_i/memwrite_i/iord_i/addr_i/wdata_i request;
//        rdata_o/ready_o/err_o response pulse; led_o MMIO output register.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic        iord_i,
    input  logic [31:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic [7:0]  led_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d, wr_q, wr_d, iord_q, iord_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ready_q, ready_d, err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  led_q, led_d;

    logic        eff_rd, eff_wr, eff_iord;
    logic [31:0] eff_addr;
    logic [31:0] ram_rdata;
    logic [7:0]  byte_sel;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic        commit_sb, commit_mmio;

    // The response is registered on entry to RESP. With WAIT_CYCLES=0 that entry
    // happens straight from IDLE, before the capture registers hold the request,
    // so the live inputs are used while in IDLE.
    always_comb begin
        eff_rd   = rd_q;
        eff_wr   = wr_q;
        eff_iord = iord_q;
        eff_addr = addr_q;
        if (state_q == IDLE) begin
            eff_rd   = memread_i;
            eff_wr   = memwrite_i;
            eff_iord = iord_i;
            eff_addr = addr_i;
        end
    end

    mem_byte_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (eff_addr[AW-1:2]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        byte_sel = ram_rdata[31:24];
        case (eff_addr[1:0])
            2'd0: byte_sel = ram_rdata[31:24];
            2'd1: byte_sel = ram_rdata[23:16];
            2'd2: byte_sel = ram_rdata[15:8];
            2'd3: byte_sel = ram_rdata[7:0];
            default: byte_sel = ram_rdata[31:24];
        endcase
    end

    // MMIO decode applies to byte accesses only; a word access to that address
    // wraps into RAM like any other address.
    always_comb begin
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        if (eff_rd && eff_wr) begin
            resp_err = 1'b1;
        end else if (eff_wr) begin
            resp_err = !eff_iord;
        end else if (eff_iord) begin
            resp_rdata = (eff_addr == MMIO_ADDR) ? {24'd0, led_q} : sext8(byte_sel);
        end else begin
            resp_rdata = ram_rdata;
            resp_err   = (eff_addr[1:0] != 2'd0);
        end
    end

    // Stores commit in the RESP cycle; gating with rst drops an aborted store.
    assign commit_sb   = (state_q == RESP) && wr_q && !rd_q && iord_q && !rst;
    assign commit_mmio = commit_sb && (addr_q == MMIO_ADDR);
    assign ram_we      = commit_sb && (addr_q != MMIO_ADDR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        iord_d  = iord_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (memread_i || memwrite_i) begin
                    rd_d    = memread_i;
                    wr_d    = memwrite_i;
                    iord_d  = iord_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d = (state_d == RESP);
        err_d   = ready_d && resp_err;
        rdata_d = ready_d ? resp_rdata : 32'd0;
        led_d   = commit_mmio ? wdata_q : led_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            iord_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 8'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            led_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            iord_q  <= iord_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
        end
    end

    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign led_o   = led_q;

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
// Latency: checks ready_o arrives WAIT_CYCLES+1 cycles after acceptance.
// Backpressure: n/a; requests are issued one at a time.
module tb_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd, wr, iord;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic        ready, err;
    logic [7:0]  led;

    logic        rd0, wr0, iord0;
    logic [31:0] addr0;
    logic [7:0]  wdata0;
    logic [31:0] rdata0;
    logic        ready0, err0;
    logic [7:0]  led0;

    mem_resp #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .memread_i(rd), .memwrite_i(wr), .iord_i(iord),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready),
        .err_o(err), .led_o(led)
    );

    mem_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .memread_i(rd0), .memwrite_i(wr0), .iord_i(iord0),
        .addr_i(addr0), .wdata_i(wdata0), .rdata_o(rdata0), .ready_o(ready0),
        .err_o(err0), .led_o(led0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitors: pop and compare on every ready pulse; outputs must be
    // quiet whenever ready is low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL w2 unexpected ready: rdata %h, no response pending", rdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("w2 rdata", rdata, e.rdata);
                    check("w2 err", {31'd0, err}, {31'd0, e.err});
                end
            end else begin
                check("w2 idle rdata", rdata, 32'd0);
                check("w2 idle err", {31'd0, err}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (ready0) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL w0 unexpected ready: rdata %h, no response pending", rdata0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("w0 rdata", rdata0, e.rdata);
                    check("w0 err", {31'd0, err0}, {31'd0, e.err});
                end
            end else begin
                check("w0 idle rdata", rdata0, 32'd0);
                check("w0 idle err", {31'd0, err0}, 32'd0);
            end
        end
    end

    // One request on the WAIT_CYCLES=2 instance; expects ready 3 cycles after acceptance.
    task automatic do_req(input logic r, input logic w, input logic io,
                          input logic [31:0] a, input logic [7:0] d,
                          input logic [31:0] er, input logic ee, input string name);
        exp_t e;
        int   n;
        e.rdata = er;
        e.err   = ee;
        q.push_back(e);
        rd = r; wr = w; iord = io; addr = a; wdata = d;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        n = 1;
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd3);
        @(posedge clk); #1;
    endtask

    // Byte store on the WAIT_CYCLES=0 instance; ready follows acceptance directly.
    task automatic do_sb0(input logic [31:0] a, input logic [7:0] d);
        exp_t e;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        q0.push_back(e);
        rd0 = 1'b0; wr0 = 1'b1; iord0 = 1'b1; addr0 = a; wdata0 = d;
        @(posedge clk); #1;
        wr0 = 1'b0;
        check("w0 sb ready", {31'd0, ready0}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        rd = 0; wr = 0; iord = 0; addr = 0; wdata = 0;
        rd0 = 0; wr0 = 0; iord0 = 0; addr0 = 0; wdata0 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset led", {24'd0, led}, 32'd0);
        check("reset w0 ready", {31'd0, ready0}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Preload 12 34 56 78 via byte stores, then read back.
        do_req(0, 1, 1, 32'h0, 8'h12, 32'h0, 0, "sb0");
        do_req(0, 1, 1, 32'h1, 8'h34, 32'h0, 0, "sb1");
        do_req(0, 1, 1, 32'h2, 8'h56, 32'h0, 0, "sb2");
        do_req(0, 1, 1, 32'h3, 8'h78, 32'h0, 0, "sb3");
        do_req(1, 0, 0, 32'h0, 8'h0, 32'h1234_5678, 0, "lw0");
        do_req(1, 0, 1, 32'h1, 8'h0, 32'h0000_0034, 0, "lb1");
        do_req(1, 0, 1, 32'h3, 8'h0, 32'h0000_0078, 0, "lb3");

        // Sign extension.
        do_req(0, 1, 1, 32'h10, 8'h80, 32'h0, 0, "sb10");
        do_req(1, 0, 1, 32'h10, 8'h0, 32'hFFFF_FF80, 0, "lb10");
        do_req(0, 1, 1, 32'h11, 8'h7F, 32'h0, 0, "sb11");
        do_req(1, 0, 1, 32'h11, 8'h0, 32'h0000_007F, 0, "lb11");

        // Misaligned word read and unsupported word write.
        do_req(1, 0, 0, 32'h2, 8'h0, 32'h1234_5678, 1, "lw2");
        do_req(0, 1, 0, 32'h0, 8'hEE, 32'h0, 1, "sw0");
        do_req(1, 0, 0, 32'h0, 8'h0, 32'h1234_5678, 0, "lw0 after sw");

        // Reset during WAIT discards the pending store.
        do_req(0, 1, 1, 32'h20, 8'h66, 32'h0, 0, "sb20");
        rd = 1'b0; wr = 1'b1; iord = 1'b1; addr = 32'h20; wdata = 8'h55;
        @(posedge clk); #1;
        wr = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort no ready", {31'd0, ready}, 32'd0);
        end
        do_req(1, 0, 1, 32'h20, 8'h0, 32'h0000_0066, 0, "lb20 after abort");

        // MMIO: 0xFFFFFF00 would wrap to RAM index 0x300 if it reached RAM.
        do_req(0, 1, 1, 32'h300, 8'h3C, 32'h0, 0, "sb300");
        do_req(0, 1, 1, 32'hFFFF_FF00, 8'hA5, 32'h0, 0, "sb mmio");
        check("led after sb", {24'd0, led}, 32'h0000_00A5);
        do_req(1, 0, 1, 32'h300, 8'h0, 32'h0000_003C, 0, "lb300");
        do_req(1, 0, 1, 32'hFFFF_FF00, 8'h0, 32'h0000_00A5, 0, "lb mmio");

        // Read and write together: error, no access.
        do_req(1, 1, 1, 32'hFFFF_FF00, 8'h11, 32'h0, 1, "both mmio");
        check("led after both", {24'd0, led}, 32'h0000_00A5);
        do_req(1, 1, 1, 32'h0, 8'h99, 32'h0, 1, "both ram");
        do_req(1, 0, 1, 32'h0, 8'h0, 32'h0000_0012, 0, "lb0 after both");

        // WAIT_CYCLES=0: held read of 0x401 wraps to word 0x000 with error.
        do_sb0(32'h0, 8'h11);
        do_sb0(32'h1, 8'h22);
        do_sb0(32'h2, 8'h33);
        do_sb0(32'h3, 8'h44);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.rdata = 32'h1122_3344;
            e.err   = 1'b1;
            q0.push_back(e);
        end
        rd0 = 1'b1; wr0 = 1'b0; iord0 = 1'b0; addr0 = 32'h401;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("w0 held ready pattern", {31'd0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        rd0 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("w2 queue drained", 32'(q.size()), 32'd0);
        check("w0 queue drained", 32'(q0.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter DEPTH, default 1024: RAM size in bytes, power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response, 0..15.
REQ-003 clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-004 memread_i  input  1  read request from the control unit.
REQ-005 memwrite_i  input  1  write request from the control unit.
REQ-006 iord_i  input  1  0 = instruction word access, 1 = data byte access.
REQ-007 addr_i  input  32  byte address.
REQ-008 wdata_i  input  8  store byte (SB).
REQ-009 rdata_o  output  32  read data, valid while ready_o is high.
REQ-010 ready_o  output  1  one-cycle completion pulse.
REQ-011 err_o  output  1  one-cycle error pulse, coincident with ready_o.
REQ-012 led_o  output  8  memory-mapped output register.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE, memread_i or memwrite_i high SHALL accept a request and capture addr_i, wdata_i, iord_i and the request type.
REQ-015 On acceptance, the FSM SHALL go to WAIT with a counter loaded to WAIT_CYCLES-1, or go directly to RESP when WAIT_CYCLES=0.
REQ-016 WAIT SHALL decrement the counter and move to RESP after it reaches 0.
REQ-017 RESP SHALL last one cycle, then return to IDLE.
REQ-018 Completion latency SHALL be WAIT_CYCLES+1 cycles from acceptance: ready_o high in RESP only.
REQ-019 Inputs SHALL be ignored outside IDLE; changes during WAIT/RESP have no effect.
REQ-020 A request still held in the IDLE cycle after RESP SHALL be accepted as a new request.
REQ-021 Memory SHALL be byte-addressed big-endian; RAM index is addr[log2(DEPTH)-1:0], so out-of-range addresses wrap.
REQ-022 A word read (iord_i=0) SHALL return bytes at A, A+1, A+2, A+3 (A = addr with bits [1:0] cleared) in rdata_o[31:24] down to [7:0].
REQ-023 A word read with addr[1:0]!=0 SHALL also pulse err_o.
REQ-024 A byte read (iord_i=1) SHALL return the byte sign-extended to 32 bits.
REQ-025 A byte write SHALL commit wdata_i to RAM in the RESP cycle; rdata_o SHALL be 0 for writes.
REQ-026 A word write (memwrite with iord_i=0) SHALL be unsupported: no RAM change, err_o pulse.
REQ-027 When memread_i and memwrite_i are both high at acceptance, the block SHALL perform no access, give rdata_o=0, and pulse err_o with ready_o.
REQ-028 Address 32'hFFFF_FF00 SHALL be MMIO: a byte write loads led_o and a byte read returns {24'b0, led_o}; RAM is untouched.
REQ-029 rdata_o SHALL be 0 whenever ready_o is low.

Reset
REQ-030 rst SHALL force IDLE, counter 0, ready_o=0, err_o=0, rdata_o=0, led_o=0.
REQ-031 rst during WAIT/RESP SHALL abort the request; a pending write is discarded.
REQ-032 RAM contents SHALL NOT be cleared by rst.

Structure
REQ-033 State encodings, the MMIO address constant and the DEPTH/WAIT_CYCLES defaults SHALL live in the shared defines file.
REQ-034 Storage SHALL be one sub-module, mem_byte_ram: synchronous byte write, asynchronous 4-byte big-endian read port.
REQ-035 All FSM and output registers SHALL be in mem_resp.

Verification
REQ-036 Preload 0x00..0x03 = 12 34 56 78; word read at 0x0, WAIT_CYCLES=2 -> ready_o 3 cycles later, rdata_o=0x12345678, err_o=0.
REQ-037 SB 0x80 to 0x10, then LB 0x10 -> rdata_o=0xFFFFFF80; LB of stored 0x7F -> 0x0000007F.
REQ-038 SB 0xA5 to 0xFFFFFF00 -> led_o=0xA5, RAM unchanged; LB 0xFFFFFF00 -> 0x000000A5.
REQ-039 memread_i and memwrite_i both high -> ready_o and err_o pulse together, rdata_o=0, no RAM or led_o change.
REQ-040 rst asserted in WAIT of SB 0x55 to 0x20 -> next cycle IDLE, no ready_o; later LB 0x20 returns the old value.
REQ-041 WAIT_CYCLES=0: held memread_i -> ready_o every 2nd cycle; word read at 0x401 with DEPTH=1024 -> data from 0x000, err_o=1.
